// File: rtl/agc_gain_ctrl.sv
// agc_gain_ctrl: automatic gain control loop fed by the Q8.8 dB power stream.
// A window of 2^AVG_LOG2 valid samples is reduced to one statistic. That
// statistic is compared with the target, and a settle/lock state machine then
// steps the front-end gain index.
// Optional build macro AGC_PEAK_DETECT_EN: the window statistic becomes the
// signed maximum of the window samples instead of the mean.
// SETTLE_CYC must be at least 1.
module agc_gain_ctrl #(
  parameter int GAIN_W       = 5,
  parameter int GAIN_MAX     = 31,
  parameter int GAIN_INIT    = 16,
  parameter int TARGET_DB_Q8 = 12800,
  parameter int HYST_Q8      = 768,
  parameter int UNLOCK_Q8    = 1536,
  parameter int AVG_LOG2     = 3,
  parameter int SETTLE_CYC   = 16,
  parameter int MAX_STEP     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_db_valid,
  input  logic [15:0]       i_db_q8,
  output logic [GAIN_W-1:0] o_gain_idx,
  output logic              o_gain_update,
  output logic              o_locked,
  output logic              o_sat
);

  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0]  WIN_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, MEASURE, EVAL, SETTLE, LOCKED} state_t;

  state_t                    state;
  logic signed [15:0]        din;
  logic signed [15:0]        stat_nxt;
  logic signed [15:0]        stat_q;
  logic                      prev_locked;
  logic [CNT_W-1:0]          cnt;
  logic [SCNT_W-1:0]         scnt;
  logic                      win_take;
  logic                      win_done;
  logic signed [17:0]        err;
  logic signed [7:0]         step;
  logic signed [15:0]        gsum;
  logic [GAIN_W-1:0]         gain_new;
  logic                      in_hyst;
  logic                      in_unlock;
  logic                      clip;

  // Rounded dB error to a gain step, limited to +/-MAX_STEP indices.
  function automatic logic signed [7:0] sat_step(input logic signed [17:0] e);
    logic signed [17:0] r;
    r = (e + 18'sd128) >>> 8;
    if (r > 18'(MAX_STEP))  return 8'(MAX_STEP);
    if (r < -18'(MAX_STEP)) return -8'(MAX_STEP);
    return 8'(r);
  endfunction

  // Clamp a candidate gain index to the legal table range.
  function automatic logic [GAIN_W-1:0] clamp_gain(input logic signed [15:0] g);
    if (g < 16'sd0)           return '0;
    if (g > 16'(GAIN_MAX))    return GAIN_W'(GAIN_MAX);
    return GAIN_W'(g);
  endfunction

  assign din      = $signed(i_db_q8);
  assign win_take = i_en && i_db_valid && ((state == MEASURE) || (state == LOCKED));
  assign win_done = win_take && (cnt == WIN_LAST);

`ifdef AGC_PEAK_DETECT_EN
  logic signed [15:0] peak;

  assign stat_nxt = (din > peak) ? din : peak;

  // Running window maximum, restarted at the most negative code each window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   peak <= 16'sh8000;
    else if (!i_en || win_done)  peak <= 16'sh8000;
    else if (win_take)           peak <= stat_nxt;
  end
`else
  localparam int ACC_W = 16 + AVG_LOG2;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;

  assign acc_nxt  = acc + $signed({{AVG_LOG2{din[15]}}, din});
  // Dropping the low AVG_LOG2 bits is the floor division by the window length.
  assign stat_nxt = acc_nxt[ACC_W-1:AVG_LOG2];

  // Running window sum, cleared whenever a window completes or the loop stops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   acc <= '0;
    else if (!i_en || win_done)  acc <= '0;
    else if (win_take)           acc <= acc_nxt;
  end
`endif

  // Evaluation arithmetic on the latched window statistic.
  assign err       = 18'(TARGET_DB_Q8) - 18'(stat_q);
  assign step      = sat_step(err);
  assign gsum      = $signed(16'(o_gain_idx)) + 16'(step);
  assign gain_new  = clamp_gain(gsum);
  assign clip      = (gsum < 16'sd0) || (gsum > 16'(GAIN_MAX));
  assign in_hyst   = (err <= 18'(HYST_Q8)) && (err >= -18'(HYST_Q8));
  assign in_unlock = (err <= 18'(UNLOCK_Q8)) && (err >= -18'(UNLOCK_Q8));

  // Loop state machine with registered gain, pulse, lock and saturation flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      o_gain_idx    <= GAIN_W'(GAIN_INIT);
      o_gain_update <= 1'b0;
      o_locked      <= 1'b0;
      o_sat         <= 1'b0;
      cnt           <= '0;
      scnt          <= '0;
      stat_q        <= '0;
      prev_locked   <= 1'b0;
    end else begin
      o_gain_update <= 1'b0;
      if (!i_en) begin
        state    <= IDLE;
        cnt      <= '0;
        scnt     <= '0;
        o_locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= MEASURE;
          MEASURE, LOCKED: begin
            if (win_done) begin
              cnt         <= '0;
              stat_q      <= stat_nxt;
              prev_locked <= (state == LOCKED);
              state       <= EVAL;
            end else if (win_take) begin
              cnt <= cnt + 1'b1;
            end
          end
          EVAL: begin
            if (in_hyst || (prev_locked && in_unlock)) begin
              o_locked <= 1'b1;
              o_sat    <= 1'b0;
              state    <= LOCKED;
            end else begin
              o_locked <= 1'b0;
              o_sat    <= clip;
              if (gain_new != o_gain_idx) begin
                o_gain_idx    <= gain_new;
                o_gain_update <= 1'b1;
                state         <= SETTLE;
              end else begin
                state <= MEASURE;
              end
            end
          end
          SETTLE: begin
            if (scnt == SETTLE_LAST) begin
              scnt  <= '0;
              state <= MEASURE;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
